regfile_wr_arbiter: RTL

Write-port arbiter for the 16 x 32 register memory of the filter processor. It shares the single write port (reg_WE, Dir_WRA, DI) between three requesters: ALU writeback, memory-load unit and host configuration loader. Each requester sits behind its own 2-entry FIFO, and grants rotate round-robin. The block also exports a per-register pending-write mask that the issue logic uses for RAW hazard stalls.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/wr_fifo2.sv | 62 ++++++
 rtl/regfile_wr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;

    // Requester indices; the index order also defines the round-robin order.
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_HOST = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wr_fifo2.sv
// Two-entry write-request FIFO. Besides the head it exposes every slot's
// address and valid bit so the top level can build the pending-write mask.
module wr_fifo2
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  wr_entry_t           push_entry,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output wr_entry_t           head,
    output logic [1:0]          occupancy,
    output logic [2*ADDR_W-1:0] entry_addr,
    output logic [1:0]          entry_valid
);

    wr_entry_t  mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    // A full FIFO refuses pushes even when it pops this cycle.
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head       = mem[rd_ptr];
    assign occupancy  = count;
    assign entry_addr = {mem[1].addr, mem[0].addr};

    // Slot k holds live data when both slots are used, or when it is the only one at the read pointer.
    always_comb begin
        entry_valid[0] = (count == 2'd2) || ((count == 2'd1) && !rd_ptr);
        entry_valid[1] = (count == 2'd2) || ((count == 2'd1) && rd_ptr);
    end

    // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register memory's single write port
// between the ALU, load unit and host loader, each behind a 2-entry FIFO.
module regfile_wr_arbiter #(
    parameter int NUM_REQ    = regfile_pkg::NUM_REQ,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      reg_WE,
    output logic [ADDR_W-1:0]         Dir_WRA,
    output logic [DATA_W-1:0]         DI,
    output logic [15:0]               pending,
    output logic [1:0]                grant_id,
    output logic [15:0]               wr_count
);

    regfile_pkg::wr_entry_t push_entry [NUM_REQ];
    regfile_pkg::wr_entry_t head       [NUM_REQ];
    logic [NUM_REQ-1:0]     full;
    logic [NUM_REQ-1:0]     empty;
    logic [NUM_REQ-1:0]     pop;
    logic [1:0]             occ        [NUM_REQ];
    logic [2*ADDR_W-1:0]    ent_addr   [NUM_REQ];
    logic [1:0]             ent_valid  [NUM_REQ];

    logic [1:0] last_grant;
    logic       sel_valid;
    logic [1:0] sel_idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        assign push_entry[i] = '{addr: req_addr[i*ADDR_W +: ADDR_W],
                                 data: req_data[i*DATA_W +: DATA_W]};
        assign req_ready[i]  = !full[i];

        wr_fifo2 u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push        (req_valid[i]),
            .push_entry  (push_entry[i]),
            .pop         (pop[i]),
            .full        (full[i]),
            .empty       (empty[i]),
            .head        (head[i]),
            .occupancy   (occ[i]),
            .entry_addr  (ent_addr[i]),
            .entry_valid (ent_valid[i])
        );
    end

    // Round-robin search: first occupied FIFO starting just after the last winner.
    always_comb begin
        int cand;
        cand      = 0;
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (!sel_valid && (occ[cand] != 2'd0)) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(cand);
            end
        end
    end

    // Pop only the winner; the empty guard is redundant with the search but keeps the FIFO contract explicit.
    always_comb begin
        pop = '0;
        if (sel_valid) begin
            pop[sel_idx] = !empty[sel_idx];
        end
    end

    // Output stage: address and data hold when idle so the memory sees stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_WE     <= 1'b0;
            Dir_WRA    <= '0;
            DI         <= '0;
            grant_id   <= 2'd0;
            wr_count   <= 16'd0;
            last_grant <= 2'(regfile_pkg::REQ_HOST);
        end else begin
            reg_WE <= sel_valid;
            if (sel_valid) begin
                Dir_WRA    <= head[sel_idx].addr;
                DI         <= head[sel_idx].data;
                grant_id   <= sel_idx;
                last_grant <= sel_idx;
                wr_count   <= wr_count + 16'd1;
            end
        end
    end

    // Pending mask: every queued entry plus the write currently on the port.
    always_comb begin
        pending = 16'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (ent_valid[i][k]) begin
                    pending = pending | (16'(1) << ent_addr[i][k*ADDR_W +: ADDR_W]);
                end
            end
        end
        if (reg_WE) begin
            pending = pending | (16'(1) << Dir_WRA);
        end
    end

endmodule
